// File: rtl/blob_locator.sv
// blob_locator: finds the pixels matching a target colour in each video frame and reports
// the sprite top-left that centres a WIDTH x HEIGHT sprite on them. Optional macro: BLOB_LOC_SMOOTH_EN.
module blob_locator #(
    parameter int H_ACTIVE   = 1024,
    parameter int V_ACTIVE   = 768,
    parameter int WIDTH      = 16,
    parameter int HEIGHT     = 16,
    parameter int MIN_PIXELS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic [23:0] pixel,
    input  logic [23:0] color,
    input  logic [7:0]  tol,
    output logic [10:0] x,
    output logic [9:0]  y,
    output logic        found,
    output logic        frame_done
);

    localparam logic [10:0] H_END   = 11'(H_ACTIVE);
    localparam logic [10:0] H_LAST  = 11'(H_ACTIVE - 1);
    localparam logic [9:0]  V_END   = 10'(V_ACTIVE);
    localparam logic [9:0]  V_LAST  = 10'(V_ACTIVE - 1);
    localparam logic [10:0] HALF_W  = 11'(WIDTH / 2);
    localparam logic [9:0]  HALF_H  = 10'(HEIGHT / 2);
    localparam logic [15:0] MIN_CNT = 16'(MIN_PIXELS);

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        ACCUM    = 2'd1,
        COMMIT   = 2'd2
    } state_t;

    function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    logic        match_s;
    logic        match_r;
    logic [10:0] hc_r;
    logic [9:0]  vc_r;
    logic        last_r;
    logic        sof_r;

    state_t      state_r;
    state_t      state_nx;
    logic        fold_s;
    logic        commit_s;

    logic [10:0] min_x_r;
    logic [10:0] max_x_r;
    logic [9:0]  min_y_r;
    logic [9:0]  max_y_r;
    logic [15:0] cnt_r;

    logic [11:0] sum_x_s;
    logic [10:0] sum_y_s;
    logic [10:0] cx_s;
    logic [9:0]  cy_s;
    logic [10:0] x_new_s;
    logic [9:0]  y_new_s;

    assign match_s = (abs_diff(pixel[23:16], color[23:16]) <= tol) &&
                     (abs_diff(pixel[15:8],  color[15:8])  <= tol) &&
                     (abs_diff(pixel[7:0],   color[7:0])   <= tol) &&
                     (hcount < H_END) && (vcount < V_END);

    // Stage 1: register the match decision with its coordinates and frame markers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            match_r <= 1'b0;
            hc_r    <= 11'd0;
            vc_r    <= 10'd0;
            last_r  <= 1'b0;
            sof_r   <= 1'b0;
        end else begin
            match_r <= match_s;
            hc_r    <= hcount;
            vc_r    <= vcount;
            last_r  <= (hcount == H_LAST) && (vcount == V_LAST);
            sof_r   <= (hcount == 11'd0) && (vcount == 10'd0);
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= WAIT_SOF;
        end else begin
            state_r <= state_nx;
        end
    end

    // FSM next state; the start-of-frame pixel is folded in on the transition out of WAIT_SOF
    always_comb begin
        state_nx = state_r;
        fold_s   = 1'b0;
        commit_s = 1'b0;
        case (state_r)
            WAIT_SOF: begin
                if (sof_r) begin
                    fold_s   = 1'b1;
                    state_nx = ACCUM;
                end else begin
                    state_nx = WAIT_SOF;
                end
            end
            ACCUM: begin
                fold_s = 1'b1;
                if (last_r) begin
                    state_nx = COMMIT;
                end else begin
                    state_nx = ACCUM;
                end
            end
            COMMIT: begin
                commit_s = 1'b1;
                state_nx = ACCUM;
            end
            default: begin
                state_nx = WAIT_SOF;
            end
        endcase
    end

    // Bounding box and match count; reinitialised on reset and when a frame is committed
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            min_x_r <= H_LAST;
            max_x_r <= 11'd0;
            min_y_r <= V_LAST;
            max_y_r <= 10'd0;
            cnt_r   <= 16'd0;
        end else if (commit_s) begin
            min_x_r <= H_LAST;
            max_x_r <= 11'd0;
            min_y_r <= V_LAST;
            max_y_r <= 10'd0;
            cnt_r   <= 16'd0;
        end else if (fold_s && match_r) begin
            min_x_r <= (hc_r < min_x_r) ? hc_r : min_x_r;
            max_x_r <= (hc_r > max_x_r) ? hc_r : max_x_r;
            min_y_r <= (vc_r < min_y_r) ? vc_r : min_y_r;
            max_y_r <= (vc_r > max_y_r) ? vc_r : max_y_r;
            cnt_r   <= (cnt_r == 16'hFFFF) ? cnt_r : (cnt_r + 16'd1);
        end
    end

    // Centre of the box, shifted back by half a sprite and clamped at the screen edge
    assign sum_x_s = {1'b0, min_x_r} + {1'b0, max_x_r};
    assign sum_y_s = {1'b0, min_y_r} + {1'b0, max_y_r};
    assign cx_s    = 11'(sum_x_s >> 1);
    assign cy_s    = 10'(sum_y_s >> 1);
    assign x_new_s = (cx_s >= HALF_W) ? (cx_s - HALF_W) : 11'd0;
    assign y_new_s = (cy_s >= HALF_H) ? (cy_s - HALF_H) : 10'd0;

`ifdef BLOB_LOC_SMOOTH_EN
    logic [11:0] avg_x_sum_s;
    logic [10:0] avg_y_sum_s;
    assign avg_x_sum_s = {1'b0, x} + {1'b0, x_new_s};
    assign avg_y_sum_s = {1'b0, y} + {1'b0, y_new_s};
`endif

    // Reported position; on a failed detection the previous position is held
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x          <= 11'd0;
            y          <= 10'd0;
            found      <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= commit_s;
            if (commit_s) begin
                if (cnt_r >= MIN_CNT) begin
                    found <= 1'b1;
`ifdef BLOB_LOC_SMOOTH_EN
                    if (found) begin
                        x <= 11'(avg_x_sum_s >> 1);
                        y <= 10'(avg_y_sum_s >> 1);
                    end else begin
                        x <= x_new_s;
                        y <= y_new_s;
                    end
`else
                    x <= x_new_s;
                    y <= y_new_s;
`endif
                end else begin
                    found <= 1'b0;
                end
            end
        end
    end

endmodule
